// File: rtl/tpu_mac.sv
// Systolic-array processing element: signed multiply-accumulate with registered
// A/B pass-through to the neighbouring cells.
module tpu_mac #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);

  localparam int PW = 2 * BITS_AB;
  localparam int XW = (BITS_C > PW) ? BITS_C : PW;

  // Full-precision product is sign-extended or truncated to the accumulator
  // width; the accumulator then wraps modulo 2^BITS_C.
  function automatic logic signed [BITS_C-1:0] fit_c(input logic signed [PW-1:0] p);
    logic signed [XW-1:0] x;
    x = XW'(p);
    return x[BITS_C-1:0];
  endfunction

  logic signed [PW-1:0]      prod_p0;
  logic signed [BITS_C-1:0]  sum_p0;
  logic signed [BITS_AB-1:0] a_p1;
  logic signed [BITS_AB-1:0] b_p1;
  logic signed [BITS_C-1:0]  c_p1;

  // Stage 0: MAC on the live inputs, not the forwarded operands.
  always_comb begin
    prod_p0 = Ain * Bin;
    sum_p0  = c_p1 + fit_c(prod_p0);
  end

  // Stage 1: operand forwarding and accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1 <= '0;
      b_p1 <= '0;
      c_p1 <= '0;
    end else if (en) begin
      a_p1 <= Ain;
      b_p1 <= Bin;
      c_p1 <= WrEn ? Cin : sum_p0;
    end
  end

  assign Aout = a_p1;
  assign Bout = b_p1;
  assign Cout = c_p1;

endmodule

// File: tb/tb_tpu_mac.sv
// Bench for tpu_mac: integer reference model checked every cycle, plus
// directed vectors with hand-computed results.
module tb_tpu_mac;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              WrEn;
  logic signed [7:0]  Ain;
  logic signed [7:0]  Bin;
  logic signed [15:0] Cin;
  logic signed [7:0]  Aout;
  logic signed [7:0]  Bout;
  logic signed [15:0] Cout;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int ma = 0;
  int mb = 0;
  int mc = 0;

  tpu_mac #(.BITS_AB(8), .BITS_C(16)) dut (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(Aout), .Bout(Bout), .Cout(Cout)
  );

  always #5 clk = ~clk;

  function automatic int wrap16(input longint v);
    longint m;
    m = v % 65536;
    if (m < 0) m += 65536;
    if (m > 32767) m -= 65536;
    return int'(m);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge and advance the model.
  task automatic step(input bit r, input bit e, input bit w,
                      input int a, input int b, input int c);
    int ia, ib, ic;
    rst = r; en = e; WrEn = w;
    Ain = 8'(a); Bin = 8'(b); Cin = 16'(c);
    ia = int'(Ain); ib = int'(Bin); ic = int'(Cin);
    @(posedge clk);
    if (r) begin
      ma = 0; mb = 0; mc = 0;
    end else if (e) begin
      ma = ia;
      mb = ib;
      mc = w ? ic : wrap16(longint'(mc) + longint'(ia) * longint'(ib));
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_aout", int'(Aout), ma);
      check("model_bout", int'(Bout), mb);
      check("model_cout", int'(Cout), mc);
    end
  end

  initial begin
    int ra, rb, rc;
    rst = 1'b1; en = 1'b0; WrEn = 1'b0; Ain = '0; Bin = '0; Cin = '0;
    @(negedge clk);

    step(1, 1, 1, 77, -9, 1234);
    chk_on = 1'b1;
    check("reset_aout", int'(Aout), 0);
    check("reset_bout", int'(Bout), 0);
    check("reset_cout", int'(Cout), 0);
    step(0, 0, 1, 11, 22, 333);
    step(0, 0, 0, 11, 22, 333);
    check("idle_cout", int'(Cout), 0);
    check("idle_aout", int'(Aout), 0);

    step(0, 1, 1, 3, -4, 100);
    check("load_aout", int'(Aout), 3);
    check("load_bout", int'(Bout), -4);
    check("load_cout", int'(Cout), 100);
    step(0, 1, 0, 3, -4, 100);
    check("mac1_cout", int'(Cout), 88);
    step(0, 1, 0, 3, -4, 100);
    check("mac2_cout", int'(Cout), 76);

    for (int i = 0; i < 24; i++) begin
      ra = int'($signed(8'($urandom)));
      rb = int'($signed(8'($urandom)));
      rc = int'($signed(16'($urandom)));
      step(0, 1, 1, ra, rb, rc);
      check("rnd_load_a", int'(Aout), ra);
      check("rnd_load_b", int'(Bout), rb);
      check("rnd_load_c", int'(Cout), rc);
      step(0, 1, 0, ra, rb, rc);
      check("rnd_mac_c", int'(Cout), wrap16(longint'(ra) * longint'(rb) + longint'(rc)));
    end

    step(0, 1, 1, -128, -128, 32767);
    step(0, 1, 0, -128, -128, 32767);
    check("wrap_cout", int'(Cout), -16385);
    step(0, 1, 1, 127, 127, 0);
    step(0, 1, 0, 127, 127, 0);
    check("maxpos_cout", int'(Cout), 16129);

    step(0, 1, 1, 5, 6, 7);
    step(0, 0, 0, -1, 2, 9);
    check("hold_aout", int'(Aout), 5);
    check("hold_bout", int'(Bout), 6);
    check("hold_cout", int'(Cout), 7);
    step(0, 0, 1, -1, 2, 9);
    check("hold_wr_aout", int'(Aout), 5);
    check("hold_wr_bout", int'(Bout), 6);
    check("hold_wr_cout", int'(Cout), 7);

    step(0, 1, 1, 10, 10, 50);
    step(0, 1, 0, 10, 10, 50);
    check("pre_rst_cout", int'(Cout), 150);
    step(1, 1, 1, 10, 10, 50);
    check("rstpri_aout", int'(Aout), 0);
    check("rstpri_bout", int'(Bout), 0);
    check("rstpri_cout", int'(Cout), 0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
